// File: rtl/ex_pkg.sv
// Shared widths, encodings and stall indices for the RV32I execute stage.
// Imported by ex_alu, ex_stage and their bench.
package ex_pkg;

  localparam int OpCodeLen      = 8;
  localparam int OpSelLen       = 3;
  localparam int StallSignalLen = 6;
  localparam logic [31:0] Zero  = 32'h0;

  localparam int STALL_IDEX  = 2;
  localparam int STALL_EXMEM = 3;

  localparam logic [OpSelLen-1:0] SEL_NOP    = 3'd0;
  localparam logic [OpSelLen-1:0] SEL_LOGIC  = 3'd1;
  localparam logic [OpSelLen-1:0] SEL_SHIFT  = 3'd2;
  localparam logic [OpSelLen-1:0] SEL_ARITH  = 3'd3;
  localparam logic [OpSelLen-1:0] SEL_BRANCH = 3'd4;
  localparam logic [OpSelLen-1:0] SEL_LOAD   = 3'd5;
  localparam logic [OpSelLen-1:0] SEL_STORE  = 3'd6;

  localparam logic [OpCodeLen-1:0] OP_NOP   = 8'd0;
  localparam logic [OpCodeLen-1:0] OP_ADD   = 8'd1;
  localparam logic [OpCodeLen-1:0] OP_SUB   = 8'd2;
  localparam logic [OpCodeLen-1:0] OP_SLT   = 8'd3;
  localparam logic [OpCodeLen-1:0] OP_SLTU  = 8'd4;
  localparam logic [OpCodeLen-1:0] OP_XOR   = 8'd5;
  localparam logic [OpCodeLen-1:0] OP_OR    = 8'd6;
  localparam logic [OpCodeLen-1:0] OP_AND   = 8'd7;
  localparam logic [OpCodeLen-1:0] OP_SLL   = 8'd8;
  localparam logic [OpCodeLen-1:0] OP_SRL   = 8'd9;
  localparam logic [OpCodeLen-1:0] OP_SRA   = 8'd10;
  localparam logic [OpCodeLen-1:0] OP_ADDI  = 8'd11;
  localparam logic [OpCodeLen-1:0] OP_SLTI  = 8'd12;
  localparam logic [OpCodeLen-1:0] OP_SLTIU = 8'd13;
  localparam logic [OpCodeLen-1:0] OP_XORI  = 8'd14;
  localparam logic [OpCodeLen-1:0] OP_ORI   = 8'd15;
  localparam logic [OpCodeLen-1:0] OP_ANDI  = 8'd16;
  localparam logic [OpCodeLen-1:0] OP_SLLI  = 8'd17;
  localparam logic [OpCodeLen-1:0] OP_SRLI  = 8'd18;
  localparam logic [OpCodeLen-1:0] OP_SRAI  = 8'd19;
  localparam logic [OpCodeLen-1:0] OP_LUI   = 8'd20;
  localparam logic [OpCodeLen-1:0] OP_AUIPC = 8'd21;
  localparam logic [OpCodeLen-1:0] OP_JAL   = 8'd22;
  localparam logic [OpCodeLen-1:0] OP_JALR  = 8'd23;
  localparam logic [OpCodeLen-1:0] OP_BEQ   = 8'd24;
  localparam logic [OpCodeLen-1:0] OP_BNE   = 8'd25;
  localparam logic [OpCodeLen-1:0] OP_BLT   = 8'd26;
  localparam logic [OpCodeLen-1:0] OP_BGE   = 8'd27;
  localparam logic [OpCodeLen-1:0] OP_BLTU  = 8'd28;
  localparam logic [OpCodeLen-1:0] OP_BGEU  = 8'd29;
  localparam logic [OpCodeLen-1:0] OP_LB    = 8'd30;
  localparam logic [OpCodeLen-1:0] OP_LH    = 8'd31;
  localparam logic [OpCodeLen-1:0] OP_LW    = 8'd32;
  localparam logic [OpCodeLen-1:0] OP_LBU   = 8'd33;
  localparam logic [OpCodeLen-1:0] OP_LHU   = 8'd34;
  localparam logic [OpCodeLen-1:0] OP_SB    = 8'd35;
  localparam logic [OpCodeLen-1:0] OP_SH    = 8'd36;
  localparam logic [OpCodeLen-1:0] OP_SW    = 8'd37;

  function automatic logic is_imm_op(input logic [OpCodeLen-1:0] op);
    return (op >= OP_ADDI) && (op <= OP_SRAI);
  endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU: arithmetic, logic, shifts, compares, link values
// and branch-condition evaluation.
module ex_alu
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [OpCodeLen-1:0] aluop_i,
  input  logic [XLEN-1:0]      r1_i,
  input  logic [XLEN-1:0]      r2_i,
  input  logic [XLEN-1:0]      imm_i,
  input  logic [XLEN-1:0]      pc_i,
  output logic [XLEN-1:0]      result_o,
  output logic                 taken_o
);

  logic [XLEN-1:0] w_op2;
  logic [4:0]      w_shamt;
  logic            w_lt;
  logic            w_ltu;
  logic            w_eq;

  assign w_op2   = is_imm_op(aluop_i) ? imm_i : r2_i;
  assign w_shamt = w_op2[4:0];
  assign w_lt    = $signed(r1_i) < $signed(w_op2);
  assign w_ltu   = r1_i < w_op2;
  assign w_eq    = r1_i == w_op2;

  always_comb begin
    result_o = '0;
    taken_o  = 1'b0;
    unique case (aluop_i)
      OP_ADD, OP_ADDI:   result_o = r1_i + w_op2;
      OP_SUB:            result_o = r1_i - w_op2;
      OP_SLT, OP_SLTI:   result_o = {{(XLEN-1){1'b0}}, w_lt};
      OP_SLTU, OP_SLTIU: result_o = {{(XLEN-1){1'b0}}, w_ltu};
      OP_XOR, OP_XORI:   result_o = r1_i ^ w_op2;
      OP_OR, OP_ORI:     result_o = r1_i | w_op2;
      OP_AND, OP_ANDI:   result_o = r1_i & w_op2;
      OP_SLL, OP_SLLI:   result_o = r1_i << w_shamt;
      OP_SRL, OP_SRLI:   result_o = r1_i >> w_shamt;
      OP_SRA, OP_SRAI:   result_o = $signed(r1_i) >>> w_shamt;
      OP_LUI:            result_o = imm_i;
      OP_AUIPC:          result_o = pc_i + imm_i;
      OP_JAL, OP_JALR: begin
        result_o = pc_i + XLEN'(4);
        taken_o  = 1'b1;
      end
      OP_BEQ:            taken_o = w_eq;
      OP_BNE:            taken_o = !w_eq;
      OP_BLT:            taken_o = w_lt;
      OP_BGE:            taken_o = !w_lt;
      OP_BLTU:           taken_o = w_ltu;
      OP_BGEU:           taken_o = !w_ltu;
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: ALU, jump resolution, forwarding to ID
// and the EX/MEM pipeline register.
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [XLEN-1:0]           r1_i,
  input  logic [XLEN-1:0]           r2_i,
  input  logic [XLEN-1:0]           imm_i,
  input  logic [REG_ADDR_W-1:0]     rd_i,
  input  logic                      rd_enable_i,
  input  logic [OpCodeLen-1:0]      aluop_i,
  input  logic [OpSelLen-1:0]       alusel_i,
  input  logic [XLEN-1:0]           pc_i,
  input  logic [StallSignalLen-1:0] stall_signal,
  output logic                      jump_flag,
  output logic [XLEN-1:0]           jump_addr,
  output logic [REG_ADDR_W-1:0]     fwd_rd_o,
  output logic                      fwd_enable_o,
  output logic [XLEN-1:0]           fwd_data_o,
  output logic                      fwd_is_load_o,
  output logic [REG_ADDR_W-1:0]     rd_o,
  output logic                      rd_enable_o,
  output logic [XLEN-1:0]           result_o,
  output logic [XLEN-1:0]           mem_addr_o,
  output logic [XLEN-1:0]           mem_wdata_o,
  output logic [OpCodeLen-1:0]      mem_op_o,
  output logic [XLEN-1:0]           pc_o
);

  logic [XLEN-1:0]       w_alu_res;
  logic                  w_alu_taken;
  logic                  w_bubble;
  logic                  w_is_br;
  logic                  w_is_jump;
  logic                  w_is_mem;
  logic                  w_is_store;
  logic                  w_rd_en;
  logic [XLEN-1:0]       w_sum;
  logic [XLEN-1:0]       w_result;
  logic [OpCodeLen-1:0]  w_mem_op;
  logic                  w_unused_stall;

  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_rd_en;
  logic [XLEN-1:0]       r_result;
  logic [XLEN-1:0]       r_mem_addr;
  logic [XLEN-1:0]       r_mem_wdata;
  logic [OpCodeLen-1:0]  r_mem_op;
  logic [XLEN-1:0]       r_pc;

  ex_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .aluop_i (aluop_i),
    .r1_i    (r1_i),
    .r2_i    (r2_i),
    .imm_i   (imm_i),
    .pc_i    (pc_i),
    .result_o(w_alu_res),
    .taken_o (w_alu_taken)
  );

  assign w_unused_stall = ^stall_signal;

  assign w_bubble  = (alusel_i == SEL_NOP) || (aluop_i == OP_NOP);
  assign w_is_jump = (aluop_i == OP_JAL) || (aluop_i == OP_JALR);

  always_comb begin
    w_is_br    = 1'b0;
    w_is_mem   = 1'b0;
    w_is_store = 1'b0;
    if (!w_bubble) begin
      unique case (1'b1)
        alusel_i == SEL_BRANCH: w_is_br = 1'b1;
        alusel_i == SEL_LOAD:   w_is_mem = 1'b1;
        alusel_i == SEL_STORE: begin
          w_is_mem   = 1'b1;
          w_is_store = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Conditional branches and stores never write the register file
  assign w_rd_en  = rd_enable_i && !w_bubble && !w_is_store &&
                    !(w_is_br && !w_is_jump);
  assign w_result = w_bubble ? '0 : w_alu_res;
  assign w_mem_op = w_is_mem ? aluop_i : '0;
  assign w_sum    = r1_i + imm_i;

  assign jump_flag = w_is_br && w_alu_taken &&
                     !stall_signal[STALL_IDEX];
  assign jump_addr = (aluop_i == OP_JALR) ?
                     {w_sum[XLEN-1:1], 1'b0} : pc_i + imm_i;

  assign fwd_rd_o      = rd_i;
  assign fwd_enable_o  = w_rd_en && (rd_i != '0);
  assign fwd_data_o    = w_result;
  assign fwd_is_load_o = alusel_i == SEL_LOAD;

  // ID/EX held while EX/MEM advances: emit a bubble, not a duplicate
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd        <= '0;
      r_rd_en     <= 1'b0;
      r_result    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_op    <= '0;
      r_pc        <= '0;
    end else if (!stall_signal[STALL_EXMEM]) begin
      if (stall_signal[STALL_IDEX]) begin
        r_rd        <= '0;
        r_rd_en     <= 1'b0;
        r_result    <= '0;
        r_mem_addr  <= '0;
        r_mem_wdata <= '0;
        r_mem_op    <= '0;
        r_pc        <= '0;
      end else begin
        r_rd        <= rd_i;
        r_rd_en     <= w_rd_en;
        r_result    <= w_result;
        r_mem_addr  <= w_sum;
        r_mem_wdata <= r2_i;
        r_mem_op    <= w_mem_op;
        r_pc        <= pc_i;
      end
    end
  end

  assign rd_o        = r_rd;
  assign rd_enable_o = r_rd_en;
  assign result_o    = r_result;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_op_o    = r_mem_op;
  assign pc_o        = r_pc;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
// Hand-computed vectors, immediate assertions per comparison.
module tb_ex_stage;
  import ex_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [31:0]               r1_i, r2_i, imm_i, pc_i;
  logic [4:0]                rd_i;
  logic                      rd_enable_i;
  logic [OpCodeLen-1:0]      aluop_i;
  logic [OpSelLen-1:0]       alusel_i;
  logic [StallSignalLen-1:0] stall_signal;
  logic                      jump_flag;
  logic [31:0]               jump_addr;
  logic [4:0]                fwd_rd_o;
  logic                      fwd_enable_o;
  logic [31:0]               fwd_data_o;
  logic                      fwd_is_load_o;
  logic [4:0]                rd_o;
  logic                      rd_enable_o;
  logic [31:0]               result_o, mem_addr_o, mem_wdata_o, pc_o;
  logic [OpCodeLen-1:0]      mem_op_o;

  int n_tests = 0;
  int n_fail  = 0;

  ex_stage dut (
    .clk          (clk),
    .rst          (rst),
    .r1_i         (r1_i),
    .r2_i         (r2_i),
    .imm_i        (imm_i),
    .rd_i         (rd_i),
    .rd_enable_i  (rd_enable_i),
    .aluop_i      (aluop_i),
    .alusel_i     (alusel_i),
    .pc_i         (pc_i),
    .stall_signal (stall_signal),
    .jump_flag    (jump_flag),
    .jump_addr    (jump_addr),
    .fwd_rd_o     (fwd_rd_o),
    .fwd_enable_o (fwd_enable_o),
    .fwd_data_o   (fwd_data_o),
    .fwd_is_load_o(fwd_is_load_o),
    .rd_o         (rd_o),
    .rd_enable_o  (rd_enable_o),
    .result_o     (result_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_op_o     (mem_op_o),
    .pc_o         (pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [OpSelLen-1:0] sel,
                       input logic [OpCodeLen-1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [4:0] rd,
                       input logic en, input logic [31:0] pc);
    alusel_i    = sel;
    aluop_i     = op;
    r1_i        = a;
    r2_i        = b;
    imm_i       = im;
    rd_i        = rd;
    rd_enable_i = en;
    pc_i        = pc;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    stall_signal = '0;
    drive(SEL_NOP, OP_NOP, 0, 0, 0, 0, 1'b0, 0);
    #1;
    chk("rst_result", result_o, 32'h0);
    chk("rst_rd_en", 32'(rd_enable_o), 32'h0);
    chk("rst_mem_op", 32'(mem_op_o), 32'h0);
    chk("rst_jump", 32'(jump_flag), 32'h0);
    #10 rst = 1'b1;

    // ADD wraps into the sign bit
    drive(SEL_ARITH, OP_ADD, 32'h7FFFFFFF, 32'h1, 0, 5'd5, 1'b1, 32'h40);
    chk("add_fwd_data", fwd_data_o, 32'h80000000);
    chk("add_fwd_en", 32'(fwd_enable_o), 32'h1);
    chk("add_fwd_rd", 32'(fwd_rd_o), 32'h5);
    chk("add_pre_edge", result_o, 32'h0);
    step();
    chk("add_result", result_o, 32'h80000000);
    chk("add_rd", 32'(rd_o), 32'h5);
    chk("add_rd_en", 32'(rd_enable_o), 32'h1);
    chk("add_pc", pc_o, 32'h40);

    drive(SEL_SHIFT, OP_SRAI, 32'h80000000, 0, 32'h24, 5'd6, 1'b1, 0);
    step();
    chk("srai_result", result_o, 32'hF8000000);

    drive(SEL_ARITH, OP_SLTU, 32'h1, 32'hFFFFFFFF, 0, 5'd2, 1'b1, 0);
    chk("sltu", fwd_data_o, 32'h1);
    drive(SEL_ARITH, OP_SLT, 32'h1, 32'hFFFFFFFF, 0, 5'd2, 1'b1, 0);
    chk("slt", fwd_data_o, 32'h0);
    drive(SEL_ARITH, OP_SUB, 32'h0, 32'h1, 0, 5'd2, 1'b1, 0);
    chk("sub_wrap", fwd_data_o, 32'hFFFFFFFF);
    drive(SEL_SHIFT, OP_SLL, 32'h1, 32'h21, 0, 5'd2, 1'b1, 0);
    chk("sll_shamt5", fwd_data_o, 32'h2);
    drive(SEL_ARITH, OP_AUIPC, 0, 0, 32'h3000, 5'd2, 1'b1, 32'h10);
    chk("auipc", fwd_data_o, 32'h3010);
    step();
    chk("auipc_rd_en", 32'(rd_enable_o), 32'h1);

    // BEQ held in ID/EX for two cycles
    stall_signal = 6'b000100;
    drive(SEL_BRANCH, OP_BEQ, 32'h3, 32'h3, 32'h20, 5'd3, 1'b1, 32'h100);
    chk("beq_stall_jf0", 32'(jump_flag), 32'h0);
    chk("beq_fwd_en", 32'(fwd_enable_o), 32'h0);
    step();
    chk("beq_stall_jf1", 32'(jump_flag), 32'h0);
    chk("beq_stall_bubble", 32'(rd_enable_o), 32'h0);
    step();
    stall_signal = '0;
    #1;
    chk("beq_fire", 32'(jump_flag), 32'h1);
    chk("beq_target", jump_addr, 32'h120);
    step();
    chk("beq_rd_en", 32'(rd_enable_o), 32'h0);
    chk("beq_pc", pc_o, 32'h100);
    drive(SEL_NOP, OP_NOP, 0, 0, 0, 0, 1'b0, 0);
    chk("beq_once", 32'(jump_flag), 32'h0);

    drive(SEL_BRANCH, OP_BNE, 32'h3, 32'h3, 32'h20, 5'd0, 1'b0, 32'h100);
    chk("bne_not_taken", 32'(jump_flag), 32'h0);
    drive(SEL_BRANCH, OP_BLTU, 32'h1, 32'hFFFFFFFF, 32'h8, 5'd0, 1'b0, 32'h10);
    chk("bltu_taken", 32'(jump_flag), 32'h1);

    drive(SEL_BRANCH, OP_JALR, 32'h1003, 0, 32'h4, 5'd1, 1'b1, 32'h200);
    chk("jalr_jf", 32'(jump_flag), 32'h1);
    chk("jalr_target", jump_addr, 32'h1006);
    chk("jalr_fwd", fwd_data_o, 32'h204);
    step();
    chk("jalr_result", result_o, 32'h204);
    chk("jalr_rd_en", 32'(rd_enable_o), 32'h1);

    drive(SEL_LOAD, OP_LW, 32'h1000, 32'hDEAD, 32'hFFFFFFFC, 5'd7, 1'b1, 0);
    chk("lw_is_load", 32'(fwd_is_load_o), 32'h1);
    step();
    chk("lw_addr", mem_addr_o, 32'h00000FFC);
    chk("lw_op", 32'(mem_op_o), 32'(OP_LW));
    chk("lw_rd", 32'(rd_o), 32'h7);

    // EX/MEM held for three edges while new work sits at the input
    stall_signal = 6'b001100;
    drive(SEL_ARITH, OP_ADD, 32'h5, 32'h6, 0, 5'd9, 1'b1, 32'h80);
    chk("hold_fwd", fwd_data_o, 32'hB);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_addr", mem_addr_o, 32'h00000FFC);
      chk("hold_op", 32'(mem_op_o), 32'(OP_LW));
    end
    stall_signal = '0;

    drive(SEL_STORE, OP_SW, 32'h2000, 32'hCAFE, 32'h8, 5'd5, 1'b1, 0);
    chk("sw_fwd_en", 32'(fwd_enable_o), 32'h0);
    step();
    chk("sw_addr", mem_addr_o, 32'h2008);
    chk("sw_wdata", mem_wdata_o, 32'hCAFE);
    chk("sw_rd_en", 32'(rd_enable_o), 32'h0);
    chk("sw_op", 32'(mem_op_o), 32'(OP_SW));

    drive(SEL_ARITH, OP_NOP, 32'h1, 32'h1, 0, 5'd4, 1'b1, 0);
    step();
    chk("bubble_rd_en", 32'(rd_enable_o), 32'h0);

    drive(SEL_ARITH, OP_ADD, 32'h1, 32'h2, 0, 5'd0, 1'b1, 0);
    chk("x0_fwd_en", 32'(fwd_enable_o), 32'h0);
    step();
    chk("x0_rd_en", 32'(rd_enable_o), 32'h1);

    drive(SEL_ARITH, OP_ADD, 32'h1, 32'h2, 0, 5'd3, 1'b1, 32'h44);
    step();
    chk("pre_rst_result", result_o, 32'h3);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_result", result_o, 32'h0);
    chk("async_rst_rd", 32'(rd_o), 32'h0);
    chk("async_rst_pc", pc_o, 32'h0);
    rst = 1'b1;
    #1;
    chk("rst_release_hold", result_o, 32'h0);
    step();
    chk("post_rst_result", result_o, 32'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
